// File: rtl/mult_div_unit_if.sv
// Operand, control and result signals between the datapath and the
// multiply/divide unit; the unit owns Hi/Lo and the Busy/Done status.
interface mult_div_unit_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    modport master (
        output Start, Op, SrcA, SrcB, HiWrite, LoWrite,
        input  Hi, Lo, Busy, Done
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, HiWrite, LoWrite,
        output Hi, Lo, Busy, Done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, sign-corrected once at the end.
module mult_div_unit (
    input logic             CLK,
    input logic             RST,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} stateType;

    stateType    state;
    logic [1:0]  opReg;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] accHi;
    logic [31:0] accLo;
    logic [5:0]  count;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;
    logic        doneReg;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic isSigned);
        return (isSigned && v[31]) ? -v : v;
    endfunction

    logic        isSigned;
    logic        isDiv;
    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic [33:0] divDiff;
    logic [63:0] product;
    logic [63:0] signedProduct;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Op[0]=0 selects the signed variants (MULT/DIV); Op[1] selects divide.
    assign isSigned      = ~opReg[0];
    assign isDiv         = opReg[1];
    assign negA          = isSigned & opA[31];
    assign negB          = isSigned & opB[31];
    assign magA          = magnitude(opA, isSigned);
    assign magB          = magnitude(opB, isSigned);
    assign mulSum        = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : 33'd0);
    assign divShift      = {accHi, accLo[31]};
    assign divDiff       = {1'b0, divShift} - {2'b00, magB};
    assign product       = {accHi, accLo};
    assign signedProduct = (negA ^ negB) ? -product : product;
    assign quotient      = (negA ^ negB) ? -accLo : accLo;
    assign remainder     = negA ? -accHi : accHi;

    assign bus.Hi   = hiReg;
    assign bus.Lo   = loReg;
    assign bus.Busy = busyReg;
    assign bus.Done = doneReg;

    // Multiply keeps the multiplier in accLo and shifts the product in from
    // the top; divide shifts dividend bits out of accLo and quotient bits in.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            opReg   <= 2'b00;
            opA     <= 32'd0;
            opB     <= 32'd0;
            accHi   <= 32'd0;
            accLo   <= 32'd0;
            count   <= 6'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        opReg   <= bus.Op;
                        opA     <= bus.SrcA;
                        opB     <= bus.SrcB;
                        accHi   <= 32'd0;
                        accLo   <= bus.Op[1] ? magnitude(bus.SrcA, ~bus.Op[0])
                                             : magnitude(bus.SrcB, ~bus.Op[0]);
                        count   <= 6'd0;
                        busyReg <= 1'b1;
                        state   <= CALC;
                    end else begin
                        if (bus.HiWrite) hiReg <= bus.SrcA;
                        if (bus.LoWrite) loReg <= bus.SrcA;
                    end
                end
                CALC: begin
                    if (isDiv) begin
                        if (!divDiff[33]) begin
                            accHi <= divDiff[31:0];
                            accLo <= {accLo[30:0], 1'b1};
                        end else begin
                            accHi <= divShift[31:0];
                            accLo <= {accLo[30:0], 1'b0};
                        end
                    end else begin
                        accHi <= mulSum[32:1];
                        accLo <= {mulSum[0], accLo[31:1]};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) state <= FINISH;
                end
                FINISH: begin
                    // A zero divisor still takes the full latency, then reports all-ones/dividend.
                    if (isDiv && opB == 32'd0) begin
                        hiReg <= opA;
                        loReg <= 32'hFFFF_FFFF;
                    end else if (isDiv) begin
                        hiReg <= remainder;
                        loReg <= quotient;
                    end else begin
                        hiReg <= signedProduct[63:32];
                        loReg <= signedProduct[31:0];
                    end
                    busyReg <= 1'b0;
                    doneReg <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected {Hi,Lo},
// a monitor pops and compares on every Done pulse.
module tb_mult_div_unit;
    logic CLK;
    logic RST;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          checkCount = 0;
    int          errorCount = 0;
    logic [63:0] expQ[$];
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, actual, expected, $time);
        end
    endtask

    // Full operation with edge-accurate Busy/Done checks; operands are
    // scrambled after edge 0 so the result must come from latched values.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo, input logic loWrite);
        @(negedge CLK);
        bus.Start   = 1'b1;
        bus.Op      = op;
        bus.SrcA    = a;
        bus.SrcB    = b;
        bus.HiWrite = 1'b0;
        bus.LoWrite = loWrite;
        expQ.push_back({expHi, expLo});
        @(posedge CLK);
        #1;
        checkOutput("busyAtEdge0", bus.Busy, 1);
        checkOutput("holdAtEdge0", {bus.Hi, bus.Lo}, {modelHi, modelLo});
        @(negedge CLK);
        bus.Start   = 1'b0;
        bus.LoWrite = 1'b0;
        bus.SrcA    = ~a;
        bus.SrcB    = ~b;
        repeat (32) @(posedge CLK);
        #1;
        checkOutput("busyAtEdge32", {bus.Busy, bus.Done}, 2'b10);
        checkOutput("holdAtEdge32", {bus.Hi, bus.Lo}, {modelHi, modelLo});
        @(posedge CLK);
        #1;
        checkOutput("doneAtEdge33", {bus.Busy, bus.Done}, 2'b01);
        modelHi = expHi;
        modelLo = expLo;
    endtask

    task automatic idleWrite(input logic hw, input logic lw, input logic [31:0] a);
        @(negedge CLK);
        bus.HiWrite = hw;
        bus.LoWrite = lw;
        bus.SrcA    = a;
        @(posedge CLK);
        #1;
        if (hw) modelHi = a;
        if (lw) modelLo = a;
        checkOutput("idleWrite", {bus.Hi, bus.Lo}, {modelHi, modelLo});
        @(negedge CLK);
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
    endtask

    // Monitor: every Done cycle must carry the oldest outstanding result.
    initial begin
        logic [63:0] expected;
        forever begin
            @(negedge CLK);
            if (bus.Done === 1'b1) begin
                checkOutput("doneWithoutBusy", {63'd0, bus.Busy}, 64'd0);
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedDone: got Hi/Lo 0x%08h_%08h, required no Done at %0t",
                             bus.Hi, bus.Lo, $time);
                end else begin
                    expected = expQ.pop_front();
                    checkOutput("result", {bus.Hi, bus.Lo}, expected);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST         = 1'b1;
        bus.Start   = 1'b1;
        bus.Op      = 2'b00;
        bus.SrcA    = 32'hFFFF_FFFF;
        bus.SrcB    = 32'h0000_0003;
        bus.HiWrite = 1'b1;
        bus.LoWrite = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("resetHiLo", {bus.Hi, bus.Lo}, 64'd0);
        checkOutput("resetStatus", {bus.Busy, bus.Done}, 2'b00);
        @(negedge CLK);
        RST         = 1'b0;
        bus.Start   = 1'b0;
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("idleAfterReset", {bus.Busy, bus.Done}, 2'b00);

        applyStimulus(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        applyStimulus(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

        // Busy edges: a second Start at edge 10 and HiWrite at edge 20 must be dropped.
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op    = 2'b11;
        bus.SrcA  = 32'd100;
        bus.SrcB  = 32'd7;
        expQ.push_back({32'd2, 32'd14});
        @(posedge CLK);
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLK);
            bus.Start   = (k == 10);
            bus.Op      = (k == 10) ? 2'b01 : 2'b11;
            bus.SrcA    = (k == 20) ? 32'hDEAD_BEEF : 32'd3;
            bus.SrcB    = 32'd3;
            bus.HiWrite = (k == 20);
            @(posedge CLK);
        end
        #1;
        checkOutput("busyCaseDone", {bus.Busy, bus.Done}, 2'b01);
        modelHi = 32'd2;
        modelLo = 32'd14;
        repeat (40) @(posedge CLK);
        #1;
        checkOutput("busyCaseHold", {bus.Hi, bus.Lo}, {modelHi, modelLo});

        idleWrite(1'b1, 1'b0, 32'h1234_5678);
        idleWrite(1'b0, 1'b1, 32'h0BAD_F00D);
        idleWrite(1'b1, 1'b1, 32'hA5A5_A5A5);
        applyStimulus(2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b1);

        // Reset at edge 15 of a MULT aborts it without any Done.
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op    = 2'b00;
        bus.SrcA  = 32'd5;
        bus.SrcB  = 32'd7;
        @(posedge CLK);
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
            RST       = (k == 15);
            @(posedge CLK);
        end
        #1;
        modelHi = 32'd0;
        modelLo = 32'd0;
        checkOutput("midResetHiLo", {bus.Hi, bus.Lo}, 64'd0);
        checkOutput("midResetStatus", {bus.Busy, bus.Done}, 2'b00);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        checkOutput("afterAbortHold", {bus.Hi, bus.Lo}, 64'd0);
        applyStimulus(2'b00, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0);
        applyStimulus(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        repeat (3) @(negedge CLK);
        checkOutput("pendingResults", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
